mux2_bist: RTL

//  Upstream stimulus/check stage for mux2: steps through all 8 {s,a,b} input patterns.

---
 rtl/mux2_bist_pkg.sv | 15 +
 rtl/mux2_bist_pattern.sv | 18 +
 rtl/mux2_bist.sv | 139 +++++++++++++
 3 files changed

// File: rtl/mux2_bist_pkg.sv
// Shared constants for the mux2 built-in self-test: FSM state codes and
// pattern/counter widths used by the decoder and the top-level sequencer.
package mux2_bist_pkg;

  localparam int N_PATTERNS = 8;
  localparam int IDX_W      = 3;
  localparam int CNT_W      = 4;

  // FSM state codes
  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] APPLY  = 2'd1;
  localparam logic [1:0] SAMPLE = 2'd2;
  localparam logic [1:0] DONE   = 2'd3;

endpackage

// File: rtl/mux2_bist_pattern.sv
// Pattern decoder for the mux2 self-test: maps idx = {s,a,b} onto the mux2
// stimulus bits and the value a correct mux2 must return for that stimulus.
module mux2_bist_pattern
  import mux2_bist_pkg::*;
(
  input  logic [IDX_W-1:0] idx,
  output logic             a,
  output logic             b,
  output logic             s,
  output logic             expected
);

  assign s        = idx[2];
  assign a        = idx[1];
  assign b        = idx[0];
  assign expected = idx[2] ? idx[0] : idx[1];

endmodule

// File: rtl/mux2_bist.sv
// Built-in self-test sequencer for mux2. Steps through all eight {s,a,b}
// patterns, holds each for HOLD_CYCLES settle cycles, samples y and keeps a
// mismatch count plus the index of the first mismatching pattern.
// Optional build macro MUX2_BIST_FAILMAP_EN adds a per-pattern fail_map output.
module mux2_bist
  import mux2_bist_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  output logic             a,
  output logic             b,
  output logic             s,
  input  logic             y,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] fail_count,
`ifdef MUX2_BIST_FAILMAP_EN
  output logic [N_PATTERNS-1:0] fail_map,
`endif
  output logic [IDX_W-1:0] first_fail_idx
);

  logic [1:0]       state, state_nxt;
  logic [IDX_W-1:0] idx, idx_nxt;
  logic [CNT_W-1:0] hold_cnt, hold_nxt;
  logic [CNT_W-1:0] fc_nxt;
  logic [IDX_W-1:0] ffi_nxt;
  logic             exp_q;
  logic             pat_a, pat_b, pat_s, pat_exp;
  logic             drive_en;
  logic             mismatch;
`ifdef MUX2_BIST_FAILMAP_EN
  logic [N_PATTERNS-1:0] map_nxt;
`endif

  // Decoder looks at the index the next cycle will hold, so the registered
  // stimulus and the registered expected value always describe the same pattern.
  mux2_bist_pattern u_pattern (
    .idx      (idx_nxt),
    .a        (pat_a),
    .b        (pat_b),
    .s        (pat_s),
    .expected (pat_exp)
  );

  assign busy     = (state == APPLY) || (state == SAMPLE);
  assign done     = (state == DONE);
  assign pass     = done && (fail_count == '0);
  // Case inequality so an undriven or unknown y is never mistaken for a match
  assign mismatch = (y !== exp_q);
  assign drive_en = (state_nxt == APPLY) || (state_nxt == SAMPLE);

  // Next-state, index, settle counter and result bookkeeping
  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    hold_nxt  = hold_cnt;
    fc_nxt    = fail_count;
    ffi_nxt   = first_fail_idx;
`ifdef MUX2_BIST_FAILMAP_EN
    map_nxt   = fail_map;
`endif
    case (state)
      IDLE, DONE: begin
        if (start) begin
          state_nxt = APPLY;
          idx_nxt   = '0;
          hold_nxt  = '0;
          fc_nxt    = '0;
          ffi_nxt   = '0;
`ifdef MUX2_BIST_FAILMAP_EN
          map_nxt   = '0;
`endif
        end
      end
      APPLY: begin
        hold_nxt = hold_cnt + CNT_W'(1);
        if (hold_cnt == CNT_W'(HOLD_CYCLES - 1)) begin
          state_nxt = SAMPLE;
        end
      end
      SAMPLE: begin
        if (mismatch) begin
          fc_nxt = fail_count + CNT_W'(1);
          if (fail_count == '0) begin
            ffi_nxt = idx;
          end
`ifdef MUX2_BIST_FAILMAP_EN
          map_nxt[idx] = 1'b1;
`endif
        end
        if (idx == IDX_W'(N_PATTERNS - 1)) begin
          state_nxt = DONE;
        end else begin
          state_nxt = APPLY;
          idx_nxt   = idx + IDX_W'(1);
          hold_nxt  = '0;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State, stimulus and result registers; reset discards any partial run
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      idx            <= '0;
      hold_cnt       <= '0;
      fail_count     <= '0;
      first_fail_idx <= '0;
      a              <= 1'b0;
      b              <= 1'b0;
      s              <= 1'b0;
      exp_q          <= 1'b0;
`ifdef MUX2_BIST_FAILMAP_EN
      fail_map       <= '0;
`endif
    end else begin
      state          <= state_nxt;
      idx            <= idx_nxt;
      hold_cnt       <= hold_nxt;
      fail_count     <= fc_nxt;
      first_fail_idx <= ffi_nxt;
      a              <= drive_en & pat_a;
      b              <= drive_en & pat_b;
      s              <= drive_en & pat_s;
      exp_q          <= drive_en & pat_exp;
`ifdef MUX2_BIST_FAILMAP_EN
      fail_map       <= map_nxt;
`endif
    end
  end

endmodule
